// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-bit right-shift controller for an external single-step
//            right shift register. Accepts one request at a time (operand,
//            amount, arithmetic/logical), steps the register once per cycle
//            through its in/enable/mode inputs, feeding its output back, and
//            returns the shifted result over a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      data width, must match the shift register width (>= 2)
//   AMT_W      shift-amount field width, $clog2(WIDTH)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present            req_ready  request can be accepted
//   req_data   operand                    req_amt    shift amount
//   req_arith  1 = sign-fill, 0 = zero-fill
//   resp_valid result available           resp_ready consumer accepts result
//   resp_data  shifted result
//   sr_in      shift register data input  sr_enable  shift register enable
//   sr_mode    shift register mode (1 = arithmetic)
//   sr_out     shift register data output
//   busy       high whenever not idle
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_arith,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_enable,
  output logic             sr_mode,
  input  logic [WIDTH-1:0] sr_out,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Number of encodable amounts; exceeds WIDTH only for non-power-of-two
  // widths, where out-of-range amounts must be clamped.
  localparam int AMT_SPAN = 1 << AMT_W;

  logic [1:0]       state_q;
  logic [1:0]       state_d;

  logic [WIDTH-1:0] op_q;
  logic [AMT_W-1:0] cnt_q;
  logic             arith_q;
  logic             zero_q;
  logic             first_q;

  logic [AMT_W-1:0] amt_eff;
  logic             accept;
  logic             last_shift;

  // --------------------------------------------------------------------------
  // Amount conditioning
  // --------------------------------------------------------------------------
  generate
    if (AMT_SPAN > WIDTH) begin : g_amt_clamp
      localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);
      assign amt_eff = (req_amt > AMT_MAX) ? AMT_MAX : req_amt;
    end else begin : g_amt_pass
      assign amt_eff = req_amt;
    end
  endgenerate

  assign accept     = (state_q == S_IDLE) && req_valid;
  // cnt_q holds the shifts still to perform, including the current cycle.
  assign last_shift = (cnt_q == AMT_W'(1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // A zero amount needs no register activity; the operand is the
          // result, so go straight to the response.
          state_d = (amt_eff == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_shift) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (registered state plus sr_out only)
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    sr_enable  = 1'b0;
    sr_in      = op_q;
    sr_mode    = arith_q;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_SHIFT: begin
        sr_enable = 1'b1;
        // First step loads the operand; later steps recirculate the
        // register's own output so each enabled edge shifts one more bit.
        sr_in     = first_q ? op_q : sr_out;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        // The register was never touched for a zero amount, so its contents
        // are stale; answer with the latched operand instead.
        resp_data  = zero_q ? op_q : sr_out;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request context and shift bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
      zero_q  <= 1'b0;
      first_q <= 1'b1;
    end else if (accept) begin
      op_q    <= req_data;
      cnt_q   <= amt_eff;
      arith_q <= req_arith;
      zero_q  <= (amt_eff == '0);
      first_q <= 1'b1;
    end else if (state_q == S_SHIFT) begin
      cnt_q   <= cnt_q - AMT_W'(1);
      first_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer. Includes a behavioural
//            single-step right shift register as the external datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [AMT_W-1:0] req_amt;
  logic             req_arith;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [WIDTH-1:0] sr_in;
  logic             sr_enable;
  logic             sr_mode;
  logic [WIDTH-1:0] sr_out;
  logic             busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_arith  (req_arith),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sr_in      (sr_in),
    .sr_enable  (sr_enable),
    .sr_mode    (sr_mode),
    .sr_out     (sr_out),
    .busy       (busy)
  );

  // External single-step right shift register (not reset: contents are
  // don't-care after reset).
  initial sr_out = 16'hDEAD;
  always @(posedge clk) begin
    if (sr_enable)
      sr_out <= sr_mode ? {sr_in[WIDTH-1], sr_in[WIDTH-1:1]}
                        : {1'b0, sr_in[WIDTH-1:1]};
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amt;
    logic             arith;
    logic [WIDTH-1:0] exp;
    int               lat;
    int               en;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the response, hold it under backpressure for
  // `stall` cycles, then complete the handshake. Ends in the IDLE cycle.
  task automatic do_req(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                        input logic ar, input int gap, input int stall,
                        output logic [WIDTH-1:0] res, output int lat,
                        output int en, output int hold_bad);
    int guard;
    repeat (gap) tick();
    req_valid = 1'b1;
    req_data  = d;
    req_amt   = a;
    req_arith = ar;
    guard = 0;
    while (!req_ready && guard < 50) begin tick(); guard++; end
    tick();                      // accept edge
    req_valid = 1'b0;
    req_data  = WIDTH'($urandom);
    lat = 1; en = 0; guard = 0;
    while (!resp_valid && guard < 100) begin
      if (sr_enable) en++;
      tick();
      lat++;
      guard++;
    end
    res = resp_data;
    hold_bad = 0;
    repeat (stall) begin
      tick();
      if (!resp_valid || resp_data !== res || sr_enable) hold_bad++;
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0]        res;
    logic [WIDTH-1:0]        exp;
    logic signed [WIDTH-1:0] sd;
    int lat, en, hb, bad, seen;

    vecs[0]  = '{16'hF0F0, 4'd4,  1'b0, 16'h0F0F, 5,  4};
    vecs[1]  = '{16'h8001, 4'd15, 1'b1, 16'hFFFF, 16, 15};
    vecs[2]  = '{16'h8001, 4'd15, 1'b0, 16'h0001, 16, 15};
    vecs[3]  = '{16'h1234, 4'd0,  1'b0, 16'h1234, 1,  0};
    vecs[4]  = '{16'h1234, 4'd0,  1'b1, 16'h1234, 1,  0};
    vecs[5]  = '{16'h8000, 4'd1,  1'b1, 16'hC000, 2,  1};
    vecs[6]  = '{16'hFFFF, 4'd15, 1'b0, 16'h0001, 16, 15};
    vecs[7]  = '{16'h7FFF, 4'd15, 1'b1, 16'h0000, 16, 15};
    vecs[8]  = '{16'h5A5A, 4'd8,  1'b1, 16'h005A, 9,  8};
    vecs[9]  = '{16'hA5A5, 4'd8,  1'b1, 16'hFFA5, 9,  8};
    vecs[10] = '{16'h8000, 4'd15, 1'b0, 16'h0001, 16, 15};

    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_amt = '0;
    req_arith = 1'b0; resp_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  32'(resp_data),  32'd0);
    check("rst_sr_enable",  32'(sr_enable),  32'd0);
    check("rst_sr_in",      32'(sr_in),      32'd0);
    check("rst_sr_mode",    32'(sr_mode),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;

    // ---------------- directed vectors ----------------
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].data, vecs[i].amt, vecs[i].arith, i % 2, i % 3, res, lat, en, hb);
      check($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_en", i),   32'(en),  32'(vecs[i].en));
      check($sformatf("vec%0d_hold", i), 32'(hb),  32'd0);
    end

    // ---------------- backpressure and back-to-back ----------------
    req_valid = 1'b1; req_data = 16'hABCD; req_amt = 4'd3; req_arith = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1; seen = 0;
    while (!resp_valid && seen < 100) begin tick(); lat++; seen++; end
    check("bp_first_lat", 32'(lat), 32'd4);
    req_valid = 1'b1; req_data = 16'h7FFF; req_amt = 4'd1; req_arith = 1'b1;
    bad = 0;
    repeat (7) begin
      if (resp_data !== 16'hF579 || req_ready || !resp_valid) bad++;
      tick();
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_first_data", 32'(resp_data), 32'hF579);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_busy",  32'(busy),      32'd0);
    tick();
    req_valid = 1'b0;
    check("bp_second_busy", 32'(busy),      32'd1);
    check("bp_second_en",   32'(sr_enable), 32'd1);
    check("bp_second_in",   32'(sr_in),     32'h7FFF);
    tick();
    check("bp_second_valid", 32'(resp_valid), 32'd1);
    check("bp_second_data",  32'(resp_data),  32'h3FFF);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // ---------------- reset mid-SHIFT ----------------
    req_valid = 1'b1; req_data = 16'hFFFF; req_amt = 4'd10; req_arith = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("mid_pre_en", 32'(sr_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en",    32'(sr_enable),  32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready),  32'd1);
    check("mid_rst_busy",  32'(busy),       32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (resp_valid || sr_enable) seen++;
    end
    check("mid_no_resp", 32'(seen), 32'd0);

    // ---------------- randomized against reference model ----------------
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] d;
      logic [AMT_W-1:0] a;
      logic             ar;
      d  = WIDTH'($urandom);
      a  = AMT_W'($urandom_range(0, WIDTH - 1));
      ar = 1'($urandom_range(0, 1));
      sd = d;
      if (ar) exp = sd >>> a;
      else    exp = d >> a;
      do_req(d, a, ar, $urandom_range(0, 2), $urandom_range(0, 3), res, lat, en, hb);
      check($sformatf("rnd%0d_data", i), 32'(res), 32'(exp));
      check($sformatf("rnd%0d_lat", i),  32'(lat), (a == 0) ? 32'd1 : 32'(a) + 32'd1);
      check($sformatf("rnd%0d_en", i),   32'(en),  32'(a));
      check($sformatf("rnd%0d_hold", i), 32'(hb),  32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
